// File: rtl/command_dispatcher.sv
// Host command dispatcher: pops command words, runs bus ops through the protocol facade,
// drives aux pins and delays locally, and pushes one response word per response-producing op.
module command_dispatcher #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CMD_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AUX_PINS   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_fifo_out_nempty,
  input  logic [FIFO_WIDTH-1:0] in_fifo_out_data,
  output logic                  in_fifo_out_pop,
  input  logic                  out_fifo_in_full,
  output logic                  out_fifo_in_shift,
  output logic [FIFO_WIDTH-1:0] out_fifo_in_data,
  output logic                  periph_go,
  output logic [1:0]            periph_op,
  output logic [DATA_WIDTH-1:0] periph_wdata,
  input  logic [DATA_WIDTH-1:0] periph_rdata,
  input  logic                  periph_data_ready,
  output logic [AUX_PINS-1:0]   aux_out,
  output logic [AUX_PINS-1:0]   aux_oe,
  input  logic [AUX_PINS-1:0]   aux_in,
  output logic                  busy
);

  localparam int unsigned CntWidth = 17;

  localparam logic [CMD_WIDTH-1:0] OpData       = CMD_WIDTH'(8'h00);
  localparam logic [CMD_WIDTH-1:0] OpStart      = CMD_WIDTH'(8'h01);
  localparam logic [CMD_WIDTH-1:0] OpStop       = CMD_WIDTH'(8'h02);
  localparam logic [CMD_WIDTH-1:0] OpAuxLow     = CMD_WIDTH'(8'h10);
  localparam logic [CMD_WIDTH-1:0] OpAuxHigh    = CMD_WIDTH'(8'h11);
  localparam logic [CMD_WIDTH-1:0] OpAuxHiz     = CMD_WIDTH'(8'h12);
  localparam logic [CMD_WIDTH-1:0] OpAuxRead    = CMD_WIDTH'(8'h13);
  localparam logic [CMD_WIDTH-1:0] OpDelayShort = CMD_WIDTH'(8'h20);
  localparam logic [CMD_WIDTH-1:0] OpDelayLong  = CMD_WIDTH'(8'h21);
  localparam logic [CMD_WIDTH-1:0] ErrTag       = '1;

  typedef enum logic [2:0] {StIdle, StExec, StPeriphWait, StRespond, StDelay} state_e;

  state_e                  state_q, state_d;
  logic [FIFO_WIDTH-1:0]   cmd_q, cmd_d;
  logic [FIFO_WIDTH-1:0]   resp_q, resp_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [AUX_PINS-1:0]     aux_out_q, aux_out_d;
  logic [AUX_PINS-1:0]     aux_oe_q, aux_oe_d;

  logic [CMD_WIDTH-1:0]    opcode;
  logic [DATA_WIDTH-1:0]   payload;
  logic                    is_periph;
  logic                    idx_valid;
  logic                    idx_in;
  logic [AUX_PINS-1:0]     idx_mask;
  logic [FIFO_WIDTH-1:0]   err_word;

  assign opcode    = cmd_q[FIFO_WIDTH-1 -: CMD_WIDTH];
  assign payload   = cmd_q[DATA_WIDTH-1:0];
  assign is_periph = (opcode == OpData) || (opcode == OpStart) || (opcode == OpStop);
  assign err_word  = {ErrTag, DATA_WIDTH'(opcode)};

  // Payload-to-pin decode; out-of-range indices leave idx_valid low.
  always_comb begin
    idx_valid = 1'b0;
    idx_in    = 1'b0;
    idx_mask  = '0;
    for (int unsigned i = 0; i < AUX_PINS; i++) begin
      if (payload == DATA_WIDTH'(i)) begin
        idx_valid   = 1'b1;
        idx_in      = aux_in[i];
        idx_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    cmd_d             = cmd_q;
    resp_d            = resp_q;
    cnt_d             = cnt_q;
    aux_out_d         = aux_out_q;
    aux_oe_d          = aux_oe_q;
    in_fifo_out_pop   = 1'b0;
    out_fifo_in_shift = 1'b0;
    out_fifo_in_data  = resp_q;
    periph_go         = 1'b0;
    periph_op         = 2'd0;
    periph_wdata      = '0;

    case (state_q)
      StIdle: begin
        if (in_fifo_out_nempty) begin
          in_fifo_out_pop = 1'b1;
          cmd_d           = in_fifo_out_data;
          state_d         = StExec;
        end
      end
      StExec: begin
        case (opcode)
          OpData, OpStart, OpStop: begin
            // Only start a bus op when its result is guaranteed a slot.
            if (!out_fifo_in_full) begin
              periph_go = 1'b1;
              state_d   = StPeriphWait;
            end
          end
          OpAuxLow, OpAuxHigh, OpAuxHiz: begin
            if (idx_valid) begin
              if (opcode == OpAuxHiz) begin
                aux_oe_d = aux_oe_q & ~idx_mask;
              end else if (opcode == OpAuxHigh) begin
                aux_oe_d  = aux_oe_q | idx_mask;
                aux_out_d = aux_out_q | idx_mask;
              end else begin
                aux_oe_d  = aux_oe_q | idx_mask;
                aux_out_d = aux_out_q & ~idx_mask;
              end
              state_d = StIdle;
            end else begin
              resp_d  = err_word;
              state_d = StRespond;
            end
          end
          OpAuxRead: begin
            resp_d  = idx_valid ? {opcode, {(DATA_WIDTH-1){1'b0}}, idx_in} : err_word;
            state_d = StRespond;
          end
          OpDelayShort: begin
            cnt_d   = CntWidth'(payload) + CntWidth'(1);
            state_d = StDelay;
          end
          OpDelayLong: begin
            cnt_d   = (CntWidth'(payload) + CntWidth'(1)) << 8;
            state_d = StDelay;
          end
          default: begin
            resp_d  = err_word;
            state_d = StRespond;
          end
        endcase
      end
      StPeriphWait: begin
        if (periph_data_ready) begin
          out_fifo_in_shift = 1'b1;
          out_fifo_in_data  = {opcode, periph_rdata};
          state_d           = StIdle;
        end
      end
      StRespond: begin
        if (!out_fifo_in_full) begin
          out_fifo_in_shift = 1'b1;
          state_d           = StIdle;
        end
      end
      StDelay: begin
        if (cnt_q <= CntWidth'(1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q == StExec && is_periph) || state_q == StPeriphWait) begin
      periph_op    = opcode[1:0];
      periph_wdata = payload;
    end

    // Reset wins in its own cycle: no strobes escape while it is asserted.
    if (reset) begin
      in_fifo_out_pop   = 1'b0;
      out_fifo_in_shift = 1'b0;
      out_fifo_in_data  = '0;
      periph_go         = 1'b0;
      periph_op         = 2'd0;
      periph_wdata      = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
      aux_out_q <= '0;
      aux_oe_q  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      aux_out_q <= aux_out_d;
      aux_oe_q  <= aux_oe_d;
    end
  end

  assign aux_out = aux_out_q;
  assign aux_oe  = aux_oe_q;
  assign busy    = (state_q != StIdle) || in_fifo_out_nempty;

endmodule

// File: tb/tb_command_dispatcher.sv
// Directed and randomized checks of command_dispatcher against FIFO/facade models and a
// command-level reference model.
module tb_command_dispatcher;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_fifo_out_nempty;
  logic [15:0] in_fifo_out_data;
  logic        in_fifo_out_pop;
  logic        out_fifo_in_full;
  logic        out_fifo_in_shift;
  logic [15:0] out_fifo_in_data;
  logic        periph_go;
  logic [1:0]  periph_op;
  logic [7:0]  periph_wdata;
  logic [7:0]  periph_rdata;
  logic        periph_data_ready;
  logic [3:0]  aux_out;
  logic [3:0]  aux_oe;
  logic [3:0]  aux_in;
  logic        busy;

  always #5 clock = ~clock;

  command_dispatcher #(
    .FIFO_WIDTH(16), .CMD_WIDTH(8), .DATA_WIDTH(8), .AUX_PINS(4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .in_fifo_out_nempty(in_fifo_out_nempty),
    .in_fifo_out_data  (in_fifo_out_data),
    .in_fifo_out_pop   (in_fifo_out_pop),
    .out_fifo_in_full  (out_fifo_in_full),
    .out_fifo_in_shift (out_fifo_in_shift),
    .out_fifo_in_data  (out_fifo_in_data),
    .periph_go         (periph_go),
    .periph_op         (periph_op),
    .periph_wdata      (periph_wdata),
    .periph_rdata      (periph_rdata),
    .periph_data_ready (periph_data_ready),
    .aux_out           (aux_out),
    .aux_oe            (aux_oe),
    .aux_in            (aux_in),
    .busy              (busy)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  int          viol     = 0;
  int          cyc      = 0;
  logic [15:0] in_q[$];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          pop_cyc[$];
  int          push_cyc[$];
  logic [3:0]  h_oe[int];
  logic [3:0]  h_out[int];
  logic        last_busy;
  int          go_cnt, go_cyc, ready_cyc;
  logic [1:0]  go_op;
  logic [7:0]  go_wdata;
  bit          fac_pending, fac_hold, fac_rand, rand_full;
  int          fac_due, fac_lat;
  logic [7:0]  fac_rdata, fac_rd;
  logic [3:0]  m_oe, m_out, m_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fac_f(input logic [7:0] w);
    return {w[3:0], w[7:4]} ^ 8'hC3;
  endfunction

  task automatic drive_in();
    in_fifo_out_nempty = (in_q.size() != 0);
    in_fifo_out_data   = (in_q.size() != 0) ? in_q[0] : 16'h0;
  endtask

  // Sample on the falling edge, update the FIFO/facade models just after the rising edge.
  task automatic tick();
    logic s_pop, s_push, s_go;
    @(negedge clock);
    s_pop = in_fifo_out_pop; s_push = out_fifo_in_shift; s_go = periph_go;
    last_busy = busy;
    if (s_pop && !in_fifo_out_nempty) viol++;
    if (s_push && out_fifo_in_full) viol++;
    if (s_pop && s_push) viol++;
    h_oe[cyc] = aux_oe; h_out[cyc] = aux_out;
    if (s_pop) pop_cyc.push_back(cyc);
    if (s_push) begin got_q.push_back(out_fifo_in_data); push_cyc.push_back(cyc); end
    if (fac_pending && fac_hold && (periph_op !== go_op || periph_wdata !== go_wdata)) viol++;
    if (s_go) begin
      if (fac_pending) viol++;
      go_cnt++; go_cyc = cyc; go_op = periph_op; go_wdata = periph_wdata;
      fac_pending = 1'b1; fac_hold = 1'b1;
      fac_due = cyc + (fac_rand ? int'($urandom_range(1, 6)) : fac_lat);
      fac_rd  = fac_rand ? fac_f(periph_wdata) : fac_rdata;
    end
    @(posedge clock);
    cyc++;
    #1;
    if (s_pop) void'(in_q.pop_front());
    periph_data_ready = 1'b0;
    if (fac_pending && cyc == fac_due) begin
      periph_data_ready = 1'b1; periph_rdata = fac_rd; fac_pending = 1'b0; ready_cyc = cyc;
    end
    if (rand_full)
      out_fifo_in_full = (fac_pending || periph_data_ready) ? 1'b0 : ($urandom_range(0, 3) == 0);
    drive_in();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      tick(); n++;
    end while (!(in_q.size() == 0 && !last_busy && !fac_pending && !periph_data_ready)
               && n < budget);
    check({tag, " completes"}, 32'(n < budget), 32'd1);
    ticks(3);
  endtask

  task automatic clear_logs();
    got_q.delete(); pop_cyc.delete(); push_cyc.delete(); go_cnt = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; fac_hold = 1'b0; tick(); reset = 1'b0;
  endtask

  task automatic model_cmd(input logic [15:0] w);
    logic [7:0] op, d;
    int idx;
    op = w[15:8]; d = w[7:0]; idx = int'(d);
    if (op <= 8'h02) exp_q.push_back({op, fac_f(d)});
    else if (op >= 8'h10 && op <= 8'h13) begin
      if (idx >= 4) exp_q.push_back({8'hFF, op});
      else if (op == 8'h10) begin m_oe[idx] = 1'b1; m_out[idx] = 1'b0; end
      else if (op == 8'h11) begin m_oe[idx] = 1'b1; m_out[idx] = 1'b1; end
      else if (op == 8'h12) m_oe[idx] = 1'b0;
      else exp_q.push_back({8'h13, 7'b0, m_in[idx]});
    end else if (op != 8'h20 && op != 8'h21) exp_q.push_back({8'hFF, op});
  endtask

  function automatic logic [15:0] rand_cmd();
    logic [7:0] op, d;
    d = 8'($urandom);
    case ($urandom_range(0, 5))
      0: op = 8'($urandom_range(0, 2));
      1, 2: begin op = 8'($urandom_range(8'h10, 8'h13)); d = 8'($urandom_range(0, 5)); end
      3: begin op = 8'h20; d = 8'($urandom_range(0, 15)); end
      4: begin
        if ($urandom_range(0, 3) == 0) begin op = 8'h21; d = 8'h00; end
        else begin op = 8'h20; d = 8'($urandom_range(0, 3)); end
      end
      default: op = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(3, 15))
                                                 : 8'($urandom_range(8'h22, 8'hFF));
    endcase
    return {op, d};
  endfunction

  initial begin
    reset = 1'b1; out_fifo_in_full = 1'b0; periph_rdata = 8'h0; periph_data_ready = 1'b0;
    aux_in = 4'b0; fac_pending = 0; fac_hold = 0; fac_rand = 0; rand_full = 0;
    fac_lat = 5; fac_rdata = 8'h00; last_busy = 1'b0;
    drive_in();
    ticks(3);
    reset = 1'b0;
    tick();
    #2;
    check("reset aux_oe", 32'(aux_oe), 32'h0);
    check("reset aux_out", 32'(aux_out), 32'h0);
    check("reset pop", 32'(in_fifo_out_pop), 32'h0);
    check("reset shift", 32'(out_fifo_in_shift), 32'h0);
    check("reset go", 32'(periph_go), 32'h0);
    check("reset op/wdata", 32'({periph_op, periph_wdata}), 32'h0);
    check("reset out data", 32'(out_fifo_in_data), 32'h0);
    check("reset busy", 32'(busy), 32'h0);

    // Aux high / low / hi-Z on pin 1.
    clear_logs();
    in_q = '{16'h1101, 16'h1001, 16'h1201}; drive_in();
    wait_idle("aux seq", 200);
    check("aux pops", 32'(pop_cyc.size()), 32'd3);
    check("aux pop spacing 1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
    check("aux pop spacing 2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
    check("aux before high", 32'({h_oe[pop_cyc[0] + 1], h_out[pop_cyc[0] + 1]}), 32'h00);
    check("aux after high", 32'({h_oe[pop_cyc[0] + 2], h_out[pop_cyc[0] + 2]}), 32'h22);
    check("aux before low", 32'({h_oe[pop_cyc[1] + 1], h_out[pop_cyc[1] + 1]}), 32'h22);
    check("aux after low", 32'({h_oe[pop_cyc[1] + 2], h_out[pop_cyc[1] + 2]}), 32'h20);
    check("aux after hiz", 32'({h_oe[pop_cyc[2] + 2], h_out[pop_cyc[2] + 2]}), 32'h00);
    check("aux no push", 32'(got_q.size()), 32'd0);

    // Peripheral data op, facade answers 0x3C five cycles after go.
    clear_logs();
    fac_lat = 5; fac_rdata = 8'h3C;
    in_q = '{16'h00A5, 16'h1203}; drive_in();
    wait_idle("periph", 200);
    check("periph go count", 32'(go_cnt), 32'd1);
    check("periph op", 32'(go_op), 32'd0);
    check("periph wdata", 32'(go_wdata), 32'hA5);
    check("periph go timing", 32'(go_cyc - pop_cyc[0]), 32'd1);
    check("periph push count", 32'(got_q.size()), 32'd1);
    check("periph response", 32'(got_q[0]), 32'h003C);
    check("periph push with ready", 32'(push_cyc[0]), 32'(ready_cyc));
    check("periph ready latency", 32'(push_cyc[0] - go_cyc), 32'd5);
    check("periph next pop", 32'(pop_cyc[1] - push_cyc[0]), 32'd1);

    // Short and long delays.
    clear_logs();
    in_q = '{16'h2009, 16'h1100}; drive_in();
    wait_idle("short delay", 200);
    check("short delay gap", 32'(pop_cyc[1] - pop_cyc[0]), 32'd12);
    check("aux pin0 high", 32'({h_oe[pop_cyc[1] + 2], h_out[pop_cyc[1] + 2]}), 32'h11);
    clear_logs();
    in_q = '{16'h21FF, 16'h1200}; drive_in();
    wait_idle("long delay", 70000);
    check("long delay gap", 32'(pop_cyc[1] - pop_cyc[0]), 32'd65538);
    check("aux pin0 hiz", 32'({h_oe[pop_cyc[1] + 2], h_out[pop_cyc[1] + 2]}), 32'h01);

    // Output FIFO full holds off bus ops and responses.
    clear_logs();
    out_fifo_in_full = 1'b1; aux_in = 4'b0101; fac_lat = 3; fac_rdata = 8'h77;
    in_q = '{16'h0055, 16'h1300}; drive_in();
    ticks(20);
    check("full no go", 32'(go_cnt), 32'd0);
    check("full no push", 32'(got_q.size()), 32'd0);
    check("full one pop", 32'(pop_cyc.size()), 32'd1);
    check("full busy", 32'(last_busy), 32'd1);
    out_fifo_in_full = 1'b0;
    wait_idle("full release", 200);
    check("release push count", 32'(got_q.size()), 32'd2);
    check("release periph resp", 32'(got_q[0]), 32'h0077);
    check("release aux read resp", 32'(got_q[1]), 32'h1301);
    clear_logs();
    out_fifo_in_full = 1'b1;
    in_q = '{16'h1302}; drive_in();
    ticks(10);
    check("respond held", 32'(got_q.size()), 32'd0);
    out_fifo_in_full = 1'b0;
    wait_idle("respond release", 100);
    check("respond word", 32'(got_q.size() == 1 ? got_q[0] : 16'hxxxx), 32'h1301);

    // Undefined opcode and out-of-range aux index.
    clear_logs();
    in_q = '{16'h7E00, 16'h1004}; drive_in();
    wait_idle("errors", 200);
    check("err count", 32'(got_q.size()), 32'd2);
    check("err undefined", 32'(got_q[0]), 32'hFF7E);
    check("err aux range", 32'(got_q[1]), 32'hFF10);
    check("err push timing", 32'(push_cyc[0] - pop_cyc[0]), 32'd2);
    #2;
    check("err aux unchanged", 32'({aux_oe, aux_out}), 32'h01);

    // Reset during PERIPH_WAIT; the late data_ready must be ignored.
    clear_logs();
    fac_lat = 20; fac_rdata = 8'h99;
    in_q = '{16'h0011}; drive_in();
    for (int i = 0; i < 20 && go_cnt == 0; i++) tick();
    check("wait go seen", 32'(go_cnt), 32'd1);
    ticks(3);
    pulse_reset();
    #2;
    check("rst wait aux", 32'({aux_oe, aux_out}), 32'h00);
    check("rst wait busy", 32'(busy), 32'd0);
    check("rst wait op/wdata", 32'({periph_op, periph_wdata}), 32'h0);
    ticks(25);
    check("rst wait late ready", 32'(got_q.size()), 32'd0);

    // Reset during a long delay, then a stray data_ready.
    clear_logs();
    in_q = '{16'h21FF}; drive_in();
    ticks(100);
    check("delay busy", 32'(last_busy), 32'd1);
    pulse_reset();
    #2;
    check("rst delay busy", 32'(busy), 32'd0);
    check("rst delay out data", 32'(out_fifo_in_data), 32'h0);
    periph_data_ready = 1'b1; periph_rdata = 8'h5A;
    ticks(5);
    check("stray ready push", 32'(got_q.size()), 32'd0);
    check("stray pops", 32'(pop_cyc.size()), 32'd1);

    // Randomized command stream with random backpressure and facade latency.
    pulse_reset();
    clear_logs(); exp_q.delete();
    m_oe = 4'b0; m_out = 4'b0; m_in = 4'($urandom); aux_in = m_in;
    fac_rand = 1; rand_full = 1;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] w;
      w = rand_cmd();
      in_q.push_back(w);
      model_cmd(w);
    end
    drive_in();
    wait_idle("random", 20000);
    rand_full = 0; out_fifo_in_full = 1'b0;
    check("rand pops", 32'(pop_cyc.size()), 32'd40);
    check("rand resp count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rand resp %0d", i), 32'(i < got_q.size() ? got_q[i] : 16'hxxxx),
            32'(exp_q[i]));
    #2;
    check("rand aux_oe", 32'(aux_oe), 32'(m_oe));
    check("rand aux_out", 32'(aux_out), 32'(m_out));

    check("handshake invariants", 32'(viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
